pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised fetch program-counter generator for the IF stage.
- Drives the instruction ROM enable and fetch address.
- Supports a configurable reset vector, instruction step and address width.
- Accepts branch redirects and pipeline-flush redirects.
- Buffers a redirect that arrives while the PC is stalled, and flags misaligned targets.

Parameters:
ADDR_W, 32, fetch address width in bits.
RESET_VECTOR, 0, first fetch address after reset; must be INSN_BYTES-aligned.
INSN_BYTES, 4, byte increment per sequential fetch; power of two, at least 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
stall_pc  input  1  1 = hold PC (no sequential advance).
flush_i  input  1  1 = redirect to flush_pc (exception/pipeline flush).
flush_pc  input  ADDR_W  flush redirect target.
branch_i  input  1  1 = redirect to branch_pc.
branch_pc  input  ADDR_W  branch redirect target.
rom_en  output  1  ROM chip enable.
pc  output  ADDR_W  current fetch address.
redirect_pending  output  1  a branch captured during stall is waiting.
misalign_o  output  1  one-cycle pulse: last accepted redirect target was misaligned.

Behaviour:
Definitions
- ALIGN_BITS = log2(INSN_BYTES).
- A target is aligned when its low ALIGN_BITS bits are zero.

Reset (rst=1 at a clock edge, in any state, including mid-redirect)
- state <= IDLE, rom_en <= 0, pc <= RESET_VECTOR.
- redirect_pending <= 0, pending target <= 0, misalign_o <= 0.

State machine: two states, IDLE and RUN.
- IDLE: rom_en=0; pc holds RESET_VECTOR.
  - flush_i, branch_i and stall_pc are all ignored; nothing is latched.
  - The first edge with rst=0 -> RUN, rom_en <= 1, pc unchanged.
  - So the first fetch presents RESET_VECTOR with rom_en=1 exactly one cycle after rst deasserts.
- RUN: rom_en stays 1 until the next reset. Each edge applies the first matching rule, in this priority order:
  1. flush_i=1: pc <= flush_pc (low ALIGN_BITS forced to 0), regardless of stall_pc. Clears redirect_pending. Any simultaneous branch_i is dropped.
  2. branch_i=1 and stall_pc=0: pc <= branch_pc (aligned). Clears redirect_pending.
  3. branch_i=1 and stall_pc=1: pc holds. Pending target <= branch_pc (aligned), redirect_pending <= 1. A newer branch overwrites an older pending one.
  4. redirect_pending=1 and stall_pc=0: pc <= pending target. redirect_pending <= 0.
  5. stall_pc=0: pc <= pc + INSN_BYTES, truncated to ADDR_W bits. Wraps to 0 from the top address with no flag.
  6. Otherwise: pc holds.

Misaligned targets
- misalign_o <= 1 for exactly one cycle on the edge that accepts a flush or branch target (rules 1-3) whose low ALIGN_BITS bits are nonzero. It is 0 on all other edges.
- With INSN_BYTES=1, misalign_o is constant 0.

Latency and outputs
- Redirect latency is one cycle: a target applied at edge N is visible on pc after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset release (ADDR_W=32, RESET_VECTOR=0x100, INSN_BYTES=4), stall_pc=0: rst high 3 cycles, then low -> cycle 1 after release: rom_en=1, pc=0x100; following cycles pc=0x104, 0x108; all other outputs 0 while rst=1.
- Stall hold: stall_pc=1 for 3 cycles at pc=0x108 -> pc stays 0x108; after release pc=0x10C next cycle.
- Branch while running: branch_i=1, branch_pc=0x2000 at pc=0x10C -> pc=0x2000 next cycle, then 0x2004.
- Branch during stall: stall_pc=1, branch_i pulses with 0x3000, then 0x4000 two cycles later, stall released after 5 cycles -> pc held throughout; redirect_pending=1 from the first pulse; pc=0x4000 on the first unstalled edge; pending cleared.
- Flush priority: flush_i=1 (flush_pc=0x80) together with branch_i=1 (branch_pc=0x500) and stall_pc=1, with a pending branch present -> pc=0x80, redirect_pending=0, branch dropped.
- Edge cases:
  - branch_pc=0x2002 -> pc=0x2000, misalign_o high exactly 1 cycle.
  - ADDR_W=8, pc=0xFC, no stall -> pc wraps to 0x00.
  - rst asserted while redirect_pending=1 -> pc=RESET_VECTOR, pending=0, rom_en=0 next cycle.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : IF-stage fetch program-counter generator. Drives the instruction
//            ROM enable and fetch address, applies flush and branch redirects,
//            holds a branch that arrives during a stall until the stall lifts,
//            and pulses a flag when an accepted target is misaligned.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int                 INSN_BYTES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect_pending,
  output logic              misalign_o
);

  // Sub-instruction offset bits; all-zero when INSN_BYTES is 1, which makes
  // the misalignment flag a constant 0 and the alignment a no-op.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSN_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSN_BYTES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              run;

  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] flush_al;
  logic [ADDR_W-1:0] branch_al;
  logic              flush_mis;
  logic              branch_mis;

  // State register: IDLE out of reset, RUN from the first released edge on.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: IDLE always leaves on the first non-reset edge; RUN is sticky.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = S_RUN;
  end

  // State decode: redirects and sequential advance only act while running.
  always_comb begin
    run = (state_q == S_RUN);
  end

  // Target alignment and misalignment detection for both redirect sources.
  always_comb begin
    flush_al   = flush_pc & ~LOW_MASK;
    branch_al  = branch_pc & ~LOW_MASK;
    flush_mis  = |(flush_pc & LOW_MASK);
    branch_mis = |(branch_pc & LOW_MASK);
  end

  // Next PC / pending-redirect selection in fixed priority order.
  always_comb begin
    rom_en_d = 1'b1;          // enabled from the IDLE->RUN edge until reset
    pc_d     = pc_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    mis_d    = 1'b0;
    if (run) begin
      if (flush_i) begin
        // Flush wins over everything, including stall and a same-cycle branch.
        pc_d   = flush_al;
        pend_d = 1'b0;
        mis_d  = flush_mis;
      end else if (branch_i && !stall_pc) begin
        pc_d   = branch_al;
        pend_d = 1'b0;
        mis_d  = branch_mis;
      end else if (branch_i) begin
        // Stalled: park the branch; a newer one replaces an older one.
        tgt_d  = branch_al;
        pend_d = 1'b1;
        mis_d  = branch_mis;
      end else if (pend_q && !stall_pc) begin
        pc_d   = tgt_q;
        pend_d = 1'b0;
      end else if (!stall_pc) begin
        pc_d   = pc_q + STEP;   // wraps silently at the top of the space
      end
    end
  end

  // Datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en_q <= 1'b0;
      pc_q     <= RESET_VECTOR;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      rom_en_q <= rom_en_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      mis_q    <= mis_d;
    end
  end

  assign rom_en           = rom_en_q;
  assign pc               = pc_q;
  assign redirect_pending = pend_q;
  assign misalign_o       = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen: a vector table for the 32-bit
//            configuration plus a short sequence on an 8-bit instance for
//            address wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance, RESET_VECTOR 0x100, 4-byte instructions
  logic        rst, stall_pc, flush_i, branch_i;
  logic [31:0] flush_pc, branch_pc;
  logic        rom_en, redirect_pending, misalign_o;
  logic [31:0] pc;

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h100), .INSN_BYTES(4)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .stall_pc         (stall_pc),
    .flush_i          (flush_i),
    .flush_pc         (flush_pc),
    .branch_i         (branch_i),
    .branch_pc        (branch_pc),
    .rom_en           (rom_en),
    .pc               (pc),
    .redirect_pending (redirect_pending),
    .misalign_o       (misalign_o)
  );

  // 8-bit instance for wrap-around, RESET_VECTOR 0xF8
  logic       rst_b;
  logic       rom_en_b, pend_b, mis_b;
  logic [7:0] pc_b;

  pc_gen #(.ADDR_W(8), .RESET_VECTOR(8'hF8), .INSN_BYTES(4)) u_dut_w8 (
    .clk              (clk),
    .rst              (rst_b),
    .stall_pc         (1'b0),
    .flush_i          (1'b0),
    .flush_pc         (8'h00),
    .branch_i         (1'b0),
    .branch_pc        (8'h00),
    .rom_en           (rom_en_b),
    .pc               (pc_b),
    .redirect_pending (pend_b),
    .misalign_o       (mis_b)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] fpc;
    logic        branch;
    logic [31:0] bpc;
    logic        e_rom;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_mis;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic [31:0] fp, input logic b,
                              input logic [31:0] bp, input logic er,
                              input logic [31:0] ep, input logic epd,
                              input logic em);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.fpc = fp; v.branch = b; v.bpc = bp;
    v.e_rom = er; v.e_pc = ep; v.e_pend = epd; v.e_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: rst stall flush fpc branch bpc | rom pc pend mis (after edge)
    vecs[0]  = mk(1,0,0,0,0,0,            0,32'h100, 0,0);
    vecs[1]  = mk(1,0,0,0,0,0,            0,32'h100, 0,0);
    vecs[2]  = mk(1,0,0,0,0,0,            0,32'h100, 0,0);
    vecs[3]  = mk(0,0,0,0,0,0,            1,32'h100, 0,0); // first fetch
    vecs[4]  = mk(0,0,0,0,0,0,            1,32'h104, 0,0);
    vecs[5]  = mk(0,0,0,0,0,0,            1,32'h108, 0,0);
    vecs[6]  = mk(0,1,0,0,0,0,            1,32'h108, 0,0); // stall hold
    vecs[7]  = mk(0,1,0,0,0,0,            1,32'h108, 0,0);
    vecs[8]  = mk(0,1,0,0,0,0,            1,32'h108, 0,0);
    vecs[9]  = mk(0,0,0,0,0,0,            1,32'h10C, 0,0);
    vecs[10] = mk(0,0,0,0,1,32'h2000,     1,32'h2000,0,0); // branch running
    vecs[11] = mk(0,0,0,0,0,0,            1,32'h2004,0,0);
    vecs[12] = mk(0,1,0,0,1,32'h3000,     1,32'h2004,1,0); // branch in stall
    vecs[13] = mk(0,1,0,0,0,0,            1,32'h2004,1,0);
    vecs[14] = mk(0,1,0,0,1,32'h4000,     1,32'h2004,1,0); // overwrite
    vecs[15] = mk(0,1,0,0,0,0,            1,32'h2004,1,0);
    vecs[16] = mk(0,1,0,0,0,0,            1,32'h2004,1,0);
    vecs[17] = mk(0,0,0,0,0,0,            1,32'h4000,0,0); // pending applied
    vecs[18] = mk(0,0,0,0,0,0,            1,32'h4004,0,0);
    vecs[19] = mk(0,1,0,0,1,32'h600,      1,32'h4004,1,0);
    vecs[20] = mk(0,1,1,32'h80,1,32'h500, 1,32'h80,  0,0); // flush priority
    vecs[21] = mk(0,1,0,0,0,0,            1,32'h80,  0,0);
    vecs[22] = mk(0,0,0,0,0,0,            1,32'h84,  0,0);
    vecs[23] = mk(0,0,0,0,1,32'h2002,     1,32'h2000,0,1); // misaligned branch
    vecs[24] = mk(0,0,0,0,0,0,            1,32'h2004,0,0);
    vecs[25] = mk(0,1,1,32'h83,0,0,       1,32'h80,  0,1); // misaligned flush
    vecs[26] = mk(0,1,0,0,0,0,            1,32'h80,  0,0);
    vecs[27] = mk(0,1,0,0,1,32'h7001,     1,32'h80,  1,1); // misaligned parked
    vecs[28] = mk(0,1,0,0,0,0,            1,32'h80,  1,0);
    vecs[29] = mk(1,1,0,0,0,0,            0,32'h100, 0,0); // reset w/ pending
    vecs[30] = mk(0,0,1,32'h40,1,32'h44,  1,32'h100, 0,0); // IDLE ignores
    vecs[31] = mk(0,0,0,0,0,0,            1,32'h104, 0,0);
    vecs[32] = mk(0,0,1,32'h1000,0,0,     1,32'h1000,0,0); // flush unstalled
    vecs[33] = mk(0,0,0,0,0,0,            1,32'h1004,0,0);

    rst = 1'b1; stall_pc = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
    flush_pc = '0; branch_pc = '0;
    rst_b = 1'b1;

    for (int i = 0; i < NV; i++) begin
      rst       = vecs[i].rst;
      stall_pc  = vecs[i].stall;
      flush_i   = vecs[i].flush;
      flush_pc  = vecs[i].fpc;
      branch_i  = vecs[i].branch;
      branch_pc = vecs[i].bpc;
      @(posedge clk);
      #1;
      check($sformatf("v%0d rom_en", i), {31'b0, rom_en}, {31'b0, vecs[i].e_rom});
      check($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d pending", i), {31'b0, redirect_pending},
            {31'b0, vecs[i].e_pend});
      check($sformatf("v%0d misalign", i), {31'b0, misalign_o},
            {31'b0, vecs[i].e_mis});
    end

    // Wrap-around on the 8-bit instance: 0xF8 -> 0xFC -> 0x00 -> 0x04
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("w8 reset pc", {24'b0, pc_b}, 32'hF8);
    check("w8 reset rom_en", {31'b0, rom_en_b}, 32'h0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("w8 first fetch pc", {24'b0, pc_b}, 32'hF8);
    check("w8 first fetch rom_en", {31'b0, rom_en_b}, 32'h1);
    @(posedge clk); #1;
    check("w8 pc FC", {24'b0, pc_b}, 32'hFC);
    @(posedge clk); #1;
    check("w8 wrap pc", {24'b0, pc_b}, 32'h00);
    check("w8 wrap no flag", {30'b0, pend_b, mis_b}, 32'h0);
    @(posedge clk); #1;
    check("w8 after wrap pc", {24'b0, pc_b}, 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
